// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 8-digit seven-segment bus.
// Waits for each anode/segment pair to settle, decodes it and keeps a per-digit image.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic [7:0] an_in,
  input  logic [2:0] rd_sel,
  output logic [3:0] rd_num,
  output logic       rd_dp,
  output logic       rd_valid,
  output logic [7:0] digit_valid,
  output logic       frame_done,
  output logic       err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic             INSTANT = (STABLE_CYCLES == 1);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [7:0]       ref_an;
  logic [7:0]       ref_seg;
  logic [7:0]       prev_an;
  logic [7:0]       seen;
  logic [7:0]       seen_n;
  logic [3:0]       digit [8];
  logic [7:0]       dp;

  logic [7:0] an_lo;
  logic       blank;
  logic       legal;
  logic       same;
  logic [2:0] pos;
  logic       load;
  logic       cap;
  logic       err_ill;
  logic       eval;
  logic [4:0] dec;
  logic       dec_ok;
  logic       dec_blank;

  // Result is {match, value}; active-high ABCDEFG in.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1111110: r = {1'b1, 4'h0};
      7'b0110000: r = {1'b1, 4'h1};
      7'b1101101: r = {1'b1, 4'h2};
      7'b1111001: r = {1'b1, 4'h3};
      7'b0110011: r = {1'b1, 4'h4};
      7'b1011011: r = {1'b1, 4'h5};
      7'b1011111: r = {1'b1, 4'h6};
      7'b1110000: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1111011: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b0011111: r = {1'b1, 4'hB};
      7'b1001110: r = {1'b1, 4'hC};
      7'b0111101: r = {1'b1, 4'hD};
      7'b1001111: r = {1'b1, 4'hE};
      7'b1000111: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  assign an_lo     = ~an_in;
  assign blank     = (an_in == 8'hFF);
  assign legal     = (an_lo != 8'h00) && ((an_lo & (an_lo - 8'd1)) == 8'h00);
  assign same      = (an_in == ref_an) && (seg_in == ref_seg);
  assign dec       = decode(~seg_in[7:1]);
  assign dec_ok    = dec[4];
  assign dec_blank = (seg_in[7:1] == 7'h7F);

  always_comb begin
    pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_in[i]) pos = i[2:0];
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    load    = 1'b0;
    cap     = 1'b0;
    err_ill = 1'b0;
    eval    = 1'b0;
    case (state)
      IDLE:   eval = 1'b1;
      SETTLE: begin
        if (!same) begin
          eval = 1'b1;
        end else if (count < STABLE) begin
          count_n = count + ONE;
          if (count_n == STABLE) begin
            cap     = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD:   eval = !same;
      default: state_n = IDLE;
    endcase
    if (eval) begin
      if (legal) begin
        load    = 1'b1;
        count_n = ONE;
        state_n = INSTANT ? HOLD : SETTLE;
        cap     = INSTANT;
      end else begin
        state_n = IDLE;
        count_n = '0;
        // A held illegal pattern reports once, not every cycle.
        err_ill = !blank && (an_in != prev_an);
      end
    end
  end

  always_comb begin
    seen_n = (&seen) ? 8'h00 : seen;
    if (cap) seen_n = seen_n | an_lo;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      ref_an      <= 8'h00;
      ref_seg     <= 8'h00;
      prev_an     <= 8'hFF;
      seen        <= 8'h00;
      dp          <= 8'h00;
      digit_valid <= 8'h00;
      rd_num      <= 4'h0;
      rd_dp       <= 1'b0;
      rd_valid    <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < 8; i++) digit[i] <= 4'h0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      prev_an    <= an_in;
      seen       <= seen_n;
      frame_done <= &seen;
      err        <= err_ill | (cap && !dec_ok && !dec_blank);
      rd_num     <= digit[rd_sel];
      rd_dp      <= dp[rd_sel];
      rd_valid   <= digit_valid[rd_sel];
      if (load) begin
        ref_an  <= an_in;
        ref_seg <= seg_in;
      end
      if (cap) begin
        digit_valid[pos] <= dec_ok;
        if (dec_ok) begin
          digit[pos] <= dec[3:0];
          dp[pos]    <= ~seg_in[0];
        end
      end
    end
  end

endmodule
